post_process: RTL and testbench
===============================

POST_PROCESS -- requirements
Module: post_process

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data bus width in bits, multiple of 8, at least 40.
REQ-002 Parameter NOC_RADIX, default 16, number of source node IDs; SEQ_W = 32 - $clog2(NOC_RADIX) (28 at default).
REQ-003 Parameter CHECK_SEQ, default 1; 1 enables per-source sequence checking, 0 ties seq_err low.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  avalonST.sink  -  upstream packets, each prefixed by one header beat (fields valid, ready, sop, eop, error, empty[$clog2(DATA_WIDTH/8)], data[DATA_WIDTH]).
REQ-007 out  avalonST.src  -  payload packets with the header beat removed; same field set as in.
REQ-008 hdr_valid  output  1  one-cycle pulse when a header beat is accepted.
REQ-009 hdr_src  output  4  source node ID of the last accepted header; held until the next header.
REQ-010 hdr_seq  output  SEQ_W  sequence number of the last accepted header; held until the next header.
REQ-011 seq_err  output  1  one-cycle pulse, coincident with hdr_valid, on a sequence mismatch.
REQ-012 proto_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 Header layout: data[DATA_WIDTH-1] is ignored; data[DATA_WIDTH-2 -: 4] is the source ID; seq bit i sits at data[DATA_WIDTH-6-i] for i = 0..SEQ_W-1 (bit-reversed order); all other bits are ignored.
REQ-014 A beat is accepted when in.valid && in.ready.
REQ-015 The FSM has two states, HDR (expect header) and PAYLOAD; reset enters HDR.
REQ-016 In HDR, an accepted beat with sop=1 and eop=0 is a header:
- it is consumed and not forwarded;
- hdr_valid pulses, hdr_src and hdr_seq are captured;
- the FSM goes to PAYLOAD with first_beat set.
REQ-017 In HDR, a beat with sop=1 and eop=1 is a header with no payload: it is dropped, hdr_valid and proto_err pulse, and the FSM stays in HDR.
REQ-018 In HDR, a beat with sop=0 is dropped, proto_err pulses, and the FSM stays in HDR.
REQ-019 In PAYLOAD, an accepted beat with sop=0 is forwarded with data, empty, error and eop unchanged; out.sop = first_beat, and first_beat then clears.
REQ-020 In PAYLOAD, a forwarded beat with eop=1 returns the FSM to HDR; a single-beat payload carries sop=1 and eop=1 on out.
REQ-021 In PAYLOAD, an accepted beat with sop=1 pulses proto_err, is treated as a header per REQ-016/017, and is not forwarded; the truncated packet is not terminated.
REQ-022 Sequence table: NOC_RADIX entries of SEQ_W bits, all reset to 0, indexed by the source ID.
REQ-023 On each header with CHECK_SEQ=1:
- seq_err pulses if hdr seq != expected[src];
- expected[src] is then set to seq+1 modulo 2^SEQ_W whether or not the check passed (resynchronise).
REQ-024 Source IDs >= NOC_RADIX pulse proto_err and do not touch the table; the header is still consumed.
REQ-025 Output path: output register plus one skid register.
- in.ready = !skid_valid && !reset; no combinational path from out.ready to in.ready.
- out.valid is driven only from the output register.
REQ-026 Latency: a payload beat accepted in cycle N is presented on out in cycle N+1 when the output register is empty or draining.
REQ-027 While out.valid=1 and out.ready=0, all out fields hold stable.
REQ-028 A payload beat arriving while out is stalled is stored in the skid register; in.ready falls the next cycle.
REQ-029 Beat order is preserved; no payload beat is dropped or duplicated; header beats never occupy the output or skid register.
REQ-030 Sustained throughput is one beat per cycle when out.ready=1; a header beat costs one input cycle and no output bubble if payload is already queued.

Reset
REQ-031 During reset and in the first cycle after it:
- out.valid, out.sop, out.eop, out.error, out.empty and out.data are 0;
- hdr_valid, seq_err and proto_err are 0;
- hdr_src and hdr_seq are 0; in.ready is 0.
REQ-032 Reset mid-packet discards the output and skid registers, returns the FSM to HDR and clears every sequence table entry; no partial packet is emitted after reset.

Verification
REQ-033 Header (src=7, seq=0), then 3 payload beats 0xA, 0xB, 0xC (last with eop, empty=2) -> out shows 3 beats, sop on 0xA, eop with empty=2 on 0xC; hdr_src=7, hdr_seq=0, seq_err=0.
REQ-034 Two packets from src 3 with seq 0 then 2 -> seq_err pulses on the second header only; the third packet with seq 3 gives no error.
REQ-035 Back-to-back 1-payload-beat packets with out.ready toggling 1010... -> no loss or reorder, fields stable while stalled, in.ready never rises while the skid register is full.
REQ-036 Non-sop beat while idle, and sop beat mid-packet -> proto_err pulses once each, neither beat appears on out, and the next legal packet passes intact.
REQ-037 Header seq = 2^28-1 then seq = 0 from src 1 -> no seq_err (wrap-around).
REQ-038 Reset asserted on the second payload beat of a 4-beat packet -> out.valid=0 after reset, src-7 expected seq returns to 0, and a new packet with seq 0 passes without error.

Source files
------------

// File: rtl/post_process_if.sv
// Avalon-ST style streaming bundle: sink modport for consumers, src modport for producers.
interface avalonST #(
    parameter int DATA_WIDTH = 64
);
    localparam int EMPTY_W = $clog2(DATA_WIDTH / 8);

    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic                  error;
    logic [EMPTY_W-1:0]    empty;
    logic [DATA_WIDTH-1:0] data;

    modport sink (input valid, sop, eop, error, empty, data, output ready);
    modport src  (output valid, sop, eop, error, empty, data, input ready);
endinterface

// File: rtl/post_process.sv
// Strips the routing header beat from each NoC packet, reports source/sequence,
// checks per-source sequence continuity and forwards the payload through a skid stage.
module post_process #(
    parameter int DATA_WIDTH = 64,
    parameter int NOC_RADIX  = 16,
    parameter int CHECK_SEQ  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    avalonST.sink                           in,
    avalonST.src                            out,
    output logic                            hdr_valid,
    output logic [3:0]                      hdr_src,
    output logic [32-$clog2(NOC_RADIX)-1:0] hdr_seq,
    output logic                            seq_err,
    output logic                            proto_err
);
    localparam int SEQ_W   = 32 - $clog2(NOC_RADIX);
    localparam int IDX_W   = $clog2(NOC_RADIX);
    localparam int EMPTY_W = $clog2(DATA_WIDTH / 8);

    typedef enum logic {HDR = 1'b0, PAYLOAD = 1'b1} state_t;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  error;
        logic [EMPTY_W-1:0]    empty;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t             state_reg, state_next;
    logic               first_beat_reg, first_beat_next;
    logic               ready_en_reg;
    logic               in_ready;

    logic               accept;
    logic               hdr_take;
    logic               fwd;
    logic               stray;
    logic               src_bad;
    logic               seq_mismatch;
    logic               proto_next;
    logic               out_free;

    logic [3:0]         src_w;
    logic [SEQ_W-1:0]   seq_w;
    logic [SEQ_W-1:0]   seq_exp;
    logic [IDX_W-1:0]   idx;
    beat_t              in_beat;

    logic               out_valid_reg;
    beat_t              out_beat_reg;
    logic               skid_valid_reg;
    beat_t              skid_beat_reg;

    logic [SEQ_W-1:0]   seq_tbl_reg [NOC_RADIX];

    logic               hdr_valid_reg;
    logic               seq_err_reg;
    logic               proto_err_reg;
    logic [3:0]         hdr_src_reg;
    logic [SEQ_W-1:0]   hdr_seq_reg;

    // Header field extraction; the sequence number is stored bit-reversed on the wire.
    assign src_w = in.data[DATA_WIDTH-2 -: 4];

    genvar gi;
    generate
        for (gi = 0; gi < SEQ_W; gi++) begin : g_seq_bits
            assign seq_w[gi] = in.data[DATA_WIDTH-6-gi];
        end
    endgenerate

    assign idx     = IDX_W'(src_w);
    assign src_bad = (32'(src_w) >= 32'(NOC_RADIX));
    assign seq_exp = seq_tbl_reg[idx];

    // ready_en_reg keeps the sink closed for the first cycle after reset.
    assign in_ready = ready_en_reg && !skid_valid_reg && !reset;
    assign out_free = !out_valid_reg || out.ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= HDR;
            first_beat_reg <= 1'b0;
            ready_en_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            first_beat_reg <= first_beat_next;
            ready_en_reg   <= 1'b1;
        end
    end

    // FSM: next-state logic; any sop beat restarts packet framing regardless of state
    always_comb begin
        state_next      = state_reg;
        first_beat_next = first_beat_reg;
        if (hdr_take) begin
            state_next      = in.eop ? HDR : PAYLOAD;
            first_beat_next = !in.eop;
        end else if (fwd) begin
            first_beat_next = 1'b0;
            if (in.eop) begin
                state_next = HDR;
            end
        end
    end

    // FSM: output decode
    always_comb begin
        accept       = in.valid && in_ready;
        hdr_take     = accept && in.sop;
        fwd          = accept && !in.sop && (state_reg == PAYLOAD);
        stray        = accept && !in.sop && (state_reg == HDR);
        proto_next   = stray || (hdr_take && (in.eop || (state_reg == PAYLOAD) || src_bad));
        seq_mismatch = hdr_take && !src_bad && (CHECK_SEQ != 0) && (seq_w != seq_exp);
        in_beat.sop   = first_beat_reg;
        in_beat.eop   = in.eop;
        in_beat.error = in.error;
        in_beat.empty = in.empty;
        in_beat.data  = in.data;
    end

    // Expected-next sequence per source; always resynchronises to the received value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NOC_RADIX; i++) begin
                seq_tbl_reg[i] <= '0;
            end
        end else if (hdr_take && !src_bad && (CHECK_SEQ != 0)) begin
            seq_tbl_reg[idx] <= seq_w + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_valid_reg <= 1'b0;
            seq_err_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            hdr_src_reg   <= '0;
            hdr_seq_reg   <= '0;
        end else begin
            hdr_valid_reg <= hdr_take;
            seq_err_reg   <= seq_mismatch;
            proto_err_reg <= proto_next;
            if (hdr_take) begin
                hdr_src_reg <= src_w;
                hdr_seq_reg <= seq_w;
            end
        end
    end

    // Output register plus skid: the skid only fills when a beat lands on a stalled output,
    // and in_ready is already low whenever the skid holds data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_beat_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_beat_reg  <= '0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_beat_reg   <= skid_beat_reg;
                skid_valid_reg <= 1'b0;
            end else if (fwd) begin
                out_valid_reg <= 1'b1;
                out_beat_reg  <= in_beat;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (fwd) begin
            skid_valid_reg <= 1'b1;
            skid_beat_reg  <= in_beat;
        end
    end

    assign in.ready  = in_ready;
    assign out.valid = out_valid_reg;
    assign out.sop   = out_beat_reg.sop;
    assign out.eop   = out_beat_reg.eop;
    assign out.error = out_beat_reg.error;
    assign out.empty = out_beat_reg.empty;
    assign out.data  = out_beat_reg.data;

    assign hdr_valid = hdr_valid_reg;
    assign hdr_src   = hdr_src_reg;
    assign hdr_seq   = hdr_seq_reg;
    assign seq_err   = seq_err_reg;
    assign proto_err = proto_err_reg;
endmodule

// File: tb/tb_post_process.sv
// Directed bench for post_process: header stripping, sequence checks, framing errors,
// backpressure through the skid stage and mid-packet reset.
module tb_post_process;
    logic        clk = 1'b0;
    logic        reset;
    logic        hdr_valid;
    logic [3:0]  hdr_src;
    logic [27:0] hdr_seq;
    logic        seq_err;
    logic        proto_err;

    always #5 clk = ~clk;

    avalonST #(.DATA_WIDTH(64)) in_if ();
    avalonST #(.DATA_WIDTH(64)) out_if ();

    post_process #(
        .DATA_WIDTH(64),
        .NOC_RADIX (16),
        .CHECK_SEQ (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_if),
        .out      (out_if),
        .hdr_valid(hdr_valid),
        .hdr_src  (hdr_src),
        .hdr_seq  (hdr_seq),
        .seq_err  (seq_err),
        .proto_err(proto_err)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        error;
        logic [2:0]  empty;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   hv_cnt = 0;
    int   se_cnt = 0;
    int   pe_cnt = 0;
    int   extra_cnt = 0;
    int   hv0, se0, pe0;
    logic toggle_mode = 1'b0;
    logic skid_chk_en = 1'b0;
    logic skid_full = 1'b0;
    logic prev_stall = 1'b0;
    exp_t prev_beat;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Header word: bit 63 and bits 30:0 carry junk that must be ignored.
    function automatic logic [63:0] hdr_word(input logic [3:0] src, input logic [27:0] seq);
        logic [63:0] w;
        w = 64'h8000_0000_2A5A_5A5A;
        w[62:59] = src;
        for (int i = 0; i < 28; i++) w[58-i] = seq[i];
        return w;
    endfunction

    task automatic monitor_step();
        exp_t cur;
        exp_t e;
        cur = {out_if.sop, out_if.eop, out_if.error, out_if.empty, out_if.data};
        if (hdr_valid === 1'b1) hv_cnt++;
        if (proto_err === 1'b1) pe_cnt++;
        if (seq_err === 1'b1) begin
            se_cnt++;
            check("seq_err_with_hdr_valid", 64'(hdr_valid), 64'd1);
        end
        if (reset !== 1'b0) begin
            prev_stall = 1'b0;
            skid_full  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_if.valid), 64'd1);
                check("stall_data_held", cur.data, prev_beat.data);
                check("stall_ctrl_held", 64'({cur.sop, cur.eop, cur.error, cur.empty}),
                      64'({prev_beat.sop, prev_beat.eop, prev_beat.error, prev_beat.empty}));
            end
            if (skid_chk_en && skid_full)
                check("in_ready_while_skid_full", 64'(in_if.ready), 64'd0);
            if (out_if.valid && out_if.ready)
                skid_full = 1'b0;
            else if (in_if.valid && in_if.ready && !in_if.sop && out_if.valid && !out_if.ready)
                skid_full = 1'b1;
            prev_stall = out_if.valid && !out_if.ready;
            prev_beat  = cur;
        end
        if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
            $display("out beat sop=%0b eop=%0b err=%0b empty=%0d data=0x%0h",
                     cur.sop, cur.eop, cur.error, cur.empty, cur.data);
            if (exp_q.size() == 0) begin
                extra_cnt++;
                check("out_extra_beat", 64'(extra_cnt), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", cur.data, e.data);
                check("out_sop", 64'(cur.sop), 64'(e.sop));
                check("out_eop", 64'(cur.eop), 64'(e.eop));
                check("out_error", 64'(cur.error), 64'(e.error));
                check("out_empty", 64'(cur.empty), 64'(e.empty));
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic s, input logic e, input logic er,
                        input logic [2:0] emp, input logic [63:0] d);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.error = er;
        in_if.empty = emp;
        in_if.data  = d;
        @(negedge clk);
        while (in_if.ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                check("send_ready_timeout", 64'(n), 64'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] src, input logic [27:0] seq, input logic e);
        $display("in header src=%0d seq=0x%0h eop=%0b", src, seq, e);
        send(1'b1, e, 1'b0, 3'd0, hdr_word(src, seq));
    endtask

    task automatic pay(input logic sop_exp, input logic e, input logic er,
                       input logic [2:0] emp, input logic [63:0] d);
        exp_q.push_back('{sop: sop_exp, eop: e, error: er, empty: emp, data: d});
        send(1'b0, e, er, emp, d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_if.valid !== 1'b0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_out_idle"}, 64'(out_if.valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        hv0 = hv_cnt;
        se0 = se_cnt;
        pe0 = pe_cnt;
    endtask

    initial begin
        reset        = 1'b1;
        in_if.valid  = 1'b0;
        in_if.sop    = 1'b0;
        in_if.eop    = 1'b0;
        in_if.error  = 1'b0;
        in_if.empty  = 3'd0;
        in_if.data   = 64'd0;
        out_if.ready = 1'b1;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            forever begin
                @(posedge clk);
                #1;
                out_if.ready = toggle_mode ? ~out_if.ready : 1'b1;
            end
        join_none

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_if.valid), 64'd0);
        check("rst_in_ready", 64'(in_if.ready), 64'd0);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_if.ready), 64'd0);
        check("post_rst_out_valid", 64'(out_if.valid), 64'd0);
        check("post_rst_out_data", out_if.data, 64'd0);
        check("post_rst_out_ctrl", 64'({out_if.sop, out_if.eop, out_if.error, out_if.empty}), 64'd0);
        check("post_rst_hdr_src", 64'(hdr_src), 64'd0);
        check("post_rst_hdr_seq", 64'(hdr_seq), 64'd0);
        check("post_rst_seq_err", 64'(seq_err), 64'd0);
        @(posedge clk);
        #1;

        // Basic packet: src 7 seq 0, three payload beats
        snap();
        send_hdr(4'd7, 28'd0, 1'b0);
        pay(1'b1, 1'b0, 1'b0, 3'd0, 64'hA);
        pay(1'b0, 1'b0, 1'b1, 3'd0, 64'hB);
        pay(1'b0, 1'b1, 1'b0, 3'd2, 64'hC);
        wait_idle("t1");
        check("t1_hdr_src", 64'(hdr_src), 64'd7);
        check("t1_hdr_seq", 64'(hdr_seq), 64'd0);
        check("t1_hdr_valid_cnt", 64'(hv_cnt - hv0), 64'd1);
        check("t1_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        check("t1_proto_err_cnt", 64'(pe_cnt - pe0), 64'd0);

        // Sequence gap on src 3: 0, 2, 3
        snap();
        send_hdr(4'd3, 28'd0, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h31);
        wait_idle("t2a");
        check("t2a_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        send_hdr(4'd3, 28'd2, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h32);
        wait_idle("t2b");
        check("t2b_seq_err_cnt", 64'(se_cnt - se0), 64'd1);
        check("t2b_hdr_seq", 64'(hdr_seq), 64'd2);
        send_hdr(4'd3, 28'd3, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd1, 64'h33);
        wait_idle("t2c");
        check("t2c_seq_err_cnt", 64'(se_cnt - se0), 64'd1);
        check("t2_proto_err_cnt", 64'(pe_cnt - pe0), 64'd0);
        check("t2_hdr_src", 64'(hdr_src), 64'd3);

        // Backpressure with out.ready toggling
        snap();
        toggle_mode = 1'b1;
        skid_chk_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_hdr(4'd5, 28'(k), 1'b0);
            pay(1'b1, 1'b1, 1'b0, 3'(k), 64'h500 + 64'(k));
        end
        send_hdr(4'd5, 28'd6, 1'b0);
        for (int k = 0; k < 6; k++)
            pay((k == 0), (k == 5), 1'b0, (k == 5) ? 3'd4 : 3'd0, 64'h560 + 64'(k));
        wait_idle("t3");
        toggle_mode = 1'b0;
        skid_chk_en = 1'b0;
        check("t3_hdr_valid_cnt", 64'(hv_cnt - hv0), 64'd7);
        check("t3_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        check("t3_proto_err_cnt", 64'(pe_cnt - pe0), 64'd0);

        // Framing violations: stray beat, sop mid-packet, header with eop
        snap();
        send(1'b0, 1'b0, 1'b0, 3'd0, 64'hDEAD);
        wait_idle("t4a");
        check("t4a_proto_err_cnt", 64'(pe_cnt - pe0), 64'd1);
        check("t4a_hdr_valid_cnt", 64'(hv_cnt - hv0), 64'd0);
        send_hdr(4'd2, 28'd0, 1'b0);
        pay(1'b1, 1'b0, 1'b0, 3'd0, 64'h21);
        send_hdr(4'd2, 28'd1, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h22);
        wait_idle("t4b");
        check("t4b_proto_err_cnt", 64'(pe_cnt - pe0), 64'd2);
        check("t4b_hdr_valid_cnt", 64'(hv_cnt - hv0), 64'd2);
        check("t4b_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        send_hdr(4'd4, 28'd0, 1'b1);
        wait_idle("t4c");
        check("t4c_proto_err_cnt", 64'(pe_cnt - pe0), 64'd3);
        check("t4c_hdr_valid_cnt", 64'(hv_cnt - hv0), 64'd3);
        check("t4c_hdr_src", 64'(hdr_src), 64'd4);
        send_hdr(4'd6, 28'd0, 1'b0);
        pay(1'b1, 1'b0, 1'b0, 3'd0, 64'h61);
        pay(1'b0, 1'b1, 1'b0, 3'd5, 64'h62);
        wait_idle("t4d");
        check("t4d_proto_err_cnt", 64'(pe_cnt - pe0), 64'd3);
        check("t4d_seq_err_cnt", 64'(se_cnt - se0), 64'd0);

        // Wrap-around on src 1: first header resyncs from 0, second follows the wrap
        snap();
        send_hdr(4'd1, 28'hFFF_FFFF, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h11);
        wait_idle("t5a");
        check("t5a_seq_err_cnt", 64'(se_cnt - se0), 64'd1);
        check("t5a_hdr_seq", 64'(hdr_seq), 64'hFFF_FFFF);
        send_hdr(4'd1, 28'd0, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h12);
        wait_idle("t5b");
        check("t5b_seq_err_cnt", 64'(se_cnt - se0), 64'd1);
        check("t5b_hdr_seq", 64'(hdr_seq), 64'd0);
        check("t5b_hdr_src", 64'(hdr_src), 64'd1);

        // Reset on the second payload beat of a 4-beat packet from src 7
        snap();
        send_hdr(4'd7, 28'd1, 1'b0);
        pay(1'b1, 1'b0, 1'b0, 3'd0, 64'h71);
        check("t6_latency_valid", 64'(out_if.valid), 64'd1);
        check("t6_latency_data", out_if.data, 64'h71);
        in_if.valid = 1'b1;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.data  = 64'h72;
        reset       = 1'b1;
        @(negedge clk);
        check("t6_rst_in_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        @(negedge clk);
        check("t6_rst_out_valid", 64'(out_if.valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_post_rst_out_valid", 64'(out_if.valid), 64'd0);
        check("t6_post_rst_in_ready", 64'(in_if.ready), 64'd0);
        check("t6_post_rst_hdr_src", 64'(hdr_src), 64'd0);
        check("t6_post_rst_hdr_seq", 64'(hdr_seq), 64'd0);
        check("t6_pre_rst_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        @(posedge clk);
        #1;
        wait_idle("t6a");
        send_hdr(4'd7, 28'd0, 1'b0);
        pay(1'b1, 1'b1, 1'b0, 3'd0, 64'h73);
        wait_idle("t6b");
        check("t6b_seq_err_cnt", 64'(se_cnt - se0), 64'd0);
        check("t6b_hdr_src", 64'(hdr_src), 64'd7);
        check("t6b_hdr_seq", 64'(hdr_seq), 64'd0);
        check("t6b_extra_beats", 64'(extra_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
